// File: rtl/addsub_seq_ctrl_if.sv
// Handshake and operand/result bundle for the nibble-serial add/subtract controller.
// master = requester/consumer side, slave = the controller.
interface addsub_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial W-bit add/subtract: one 4-bit slice reused LSB first, valid/ready on both sides.
// state  | meaning
// IDLE   | waiting for in_valid, previous result held
// RUN    | one nibble per cycle, index 0..NIBBLES-1
// DONE   | result/cout/ovf presented until out_ready
module addsub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_seq_ctrl_if.slave     bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             last_nib;
  logic [3:0]       a_nib;
  logic [3:0]       bx_nib;
  logic [4:0]       slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = bus.in_valid ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_nib ? S_DONE : S_RUN;
      S_DONE:  state_d = bus.out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // The single 4-bit slice; subtraction is A + ~B + 1 with the +1 preloaded into carry.
  always_comb begin
    last_nib = (idx_q == LAST_IDX);
    a_nib    = a_q[int'(idx_q) * 4 +: 4];
    bx_nib   = b_q[int'(idx_q) * 4 +: 4] ^ {4{sub_q}};
    slice    = {1'b0, a_nib} + {1'b0, bx_nib} + {4'd0, carry_q};
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          sub_d   = bus.op_sub;
          carry_d = bus.op_sub;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        result_d[int'(idx_q) * 4 +: 4] = slice[3:0];
        carry_d = slice[4];
        idx_d   = last_nib ? '0 : idx_q + 1'b1;
        if (last_nib) begin
          cout_d = slice[4];
          ovf_d  = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (slice[3] != a_q[W-1]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed + random checks of addsub_seq_ctrl against a plain-arithmetic reference model.
module tb_addsub_seq_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam longint MAXS = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINS = -(64'sd1 <<< (W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errs = 0;

  addsub_seq_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  addsub_seq_ctrl #(.NIBBLES(NIBBLES)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] r, output logic c, output logic o);
    longint unsigned ua, ub, ur;
    longint sa, sb, sr;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur >= (64'd1 << W));
    end
    r = ur[W-1:0];
    o = (sr > MAXS) || (sr < MINS);
  endfunction

  task automatic scramble();
    bus.op_a   = W'($urandom);
    bus.op_b   = W'($urandom);
    bus.op_sub = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int stall, input bit noisy);
    logic [W-1:0] er;
    logic         ec, eo;
    int           lat;
    model(a, b, sub, er, ec, eo);
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.op_sub    = sub;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("run_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = noisy;
    scramble();
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      scramble();
    end
    chk("latency", lat, NIBBLES);
    chk("result", 32'(bus.result), 32'(er));
    chk("cout", 32'(bus.cout), 32'(ec));
    chk("ovf", 32'(bus.ovf), 32'(eo));
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = noisy;
      @(posedge clk);
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_result", 32'(bus.result), 32'(er));
      chk("stall_cout", 32'(bus.cout), 32'(ec));
      chk("stall_ovf", 32'(bus.ovf), 32'(eo));
      scramble();
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_out_valid", 32'(bus.out_valid), 0);
    chk("post_in_ready", 32'(bus.in_ready), 1);
    chk("idle_result_held", 32'(bus.result), 32'(er));
    chk("idle_cout_held", 32'(bus.cout), 32'(ec));
    chk("idle_ovf_held", 32'(bus.ovf), 32'(eo));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_cout", 32'(bus.cout), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FCD, 1'b0, 0, 1'b0);
    chk("spec_sum_2201", 32'(bus.result), 32'h2201);
    run_op(16'h0005, 16'h0007, 1'b1, 1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 2, 1'b0);
    run_op(16'h1111, 16'h2222, 1'b0, 3, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b1);

    // Reset during the second RUN cycle of a fresh operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a     = 16'hAAAA;
    bus.op_b     = 16'h1111;
    bus.op_sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", 32'(bus.in_ready), 1);
    chk("midrun_rst_out_valid", 32'(bus.out_valid), 0);
    chk("midrun_rst_result", 32'(bus.result), 0);
    chk("midrun_rst_cout", 32'(bus.cout), 0);
    chk("midrun_rst_ovf", 32'(bus.ovf), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_in_ready", 32'(bus.in_ready), 1);
    chk("rel_out_valid", 32'(bus.out_valid), 0);
    run_op(16'h1234, 16'h0FCD, 1'b0, 0, 1'b0);
    chk("after_rst_2201", 32'(bus.result), 32'h2201);

    run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
